// File: rtl/pipe_pkg.sv
// Shared definitions for the EXE-stage hazard and sequencing controller:
// forward-select codes, the mul/div FSM encoding and the default mul/div latency.
package pipe_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMO  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  localparam int MDU_LAT_DEF = 4;

endpackage

// File: rtl/pipe_exe_ctrl_fwd_sel.sv
// Operand forward select for one ID-stage source register; EXE beats MEM,
// register 0 is never forwarded.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] ern,
  input  logic       mwreg,
  input  logic       mm2reg,
  input  logic [4:0] mrn,
  output logic [1:0] sel
);

  logic e_hit_s;
  logic m_hit_s;

  assign e_hit_s = ewreg && (ern != 5'd0) && (ern == src);
  assign m_hit_s = mwreg && (mrn != 5'd0) && (mrn == src);

  // An EXE load match is resolved by the load-use stall, so it still masks MEM.
  always_comb begin
    sel = FWD_RF;
    if (!use_src) begin
      sel = FWD_RF;
    end else if (e_hit_s) begin
      sel = em2reg ? FWD_RF : FWD_EALU;
    end else if (m_hit_s) begin
      sel = mm2reg ? FWD_MMO : FWD_MALU;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_exe_ctrl.sv
// EXE-stage controller: operand forwarding, load-use bubbles, mul/div
// occupancy sequencing and a saturating stall-cycle counter.
module pipe_exe_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             e_mdu_start,
  input  logic             id_flush,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             exe_hold,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0]       LAT_INIT = 4'(MDU_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  mdu_state_e       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mdu_done_q, mdu_done_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;
  logic       lu_s;
  logic       busy_s;
  logic       wpcir_s;

  fwd_sel u_fwd_a (
    .src     (rs),
    .use_src (use_rs),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mrn     (mrn),
    .sel     (sel_a_s)
  );

  fwd_sel u_fwd_b (
    .src     (rt),
    .use_src (use_rt),
    .ewreg   (ewreg),
    .em2reg  (em2reg),
    .ern     (ern),
    .mwreg   (mwreg),
    .mm2reg  (mm2reg),
    .mrn     (mrn),
    .sel     (sel_b_s)
  );

  assign lu_s = ewreg && em2reg && (ern != 5'd0) &&
                ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

  // FSM state, latency counter, done pulse and stall counter registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      mdu_done_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mdu_done_q  <= mdu_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state: start is only honoured from IDLE or DONE, so ops can chain
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (e_mdu_start) begin
          state_d = S_BUSY;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          state_d = S_BUSY;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          state_d = S_DONE;
          cnt_d   = 4'd0;
        end
      end
      S_DONE: begin
        if (e_mdu_start) begin
          state_d = S_BUSY;
          cnt_d   = LAT_INIT;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    mdu_done_d = (state_d == S_DONE);
  end

  // Outputs: reset forces a safe pipeline view (NOP injected, front end free)
  always_comb begin
    busy_s = (state_q == S_BUSY) ||
             (((state_q == S_IDLE) || (state_q == S_DONE)) && e_mdu_start);
    wpcir_s  = 1'b1;
    fwda     = FWD_RF;
    fwdb     = FWD_RF;
    bubble   = 1'b1;
    exe_hold = 1'b0;
    mdu_busy = 1'b0;
    if (!resetn) begin
      wpcir_s  = 1'b1;
      fwda     = FWD_RF;
      fwdb     = FWD_RF;
      bubble   = 1'b1;
      exe_hold = 1'b0;
      mdu_busy = 1'b0;
    end else begin
      wpcir_s  = !(busy_s || lu_s);
      fwda     = sel_a_s;
      fwdb     = sel_b_s;
      bubble   = !busy_s && (lu_s || id_flush);
      exe_hold = busy_s;
      mdu_busy = busy_s;
    end
  end

  // Stall counter saturates rather than wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!wpcir_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign wpcir     = wpcir_s;
  assign mdu_done  = mdu_done_q;
  assign stall_cnt = stall_cnt_q;

endmodule
